// File: rtl/multi_pulse_shaper_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_pulse_shaper_if
// Description : Channel bus for multi_pulse_shaper. Carries the raw strobes,
//               the shared control bits and the conditioned per-channel outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_pulse_shaper_if #(
  parameter int CH_NUM = 4
);
  logic [CH_NUM-1:0] iS;
  logic [1:0]        iMODE;
  logic              iRETRIG;
  logic              iCLR;
  logic [CH_NUM-1:0] oS;
  logic [CH_NUM-1:0] oLEVEL;
  logic [CH_NUM-1:0] oEDGE;
  logic [CH_NUM-1:0] oOVR;
  logic              oBUSY;

  // Shaper side: consumes strobes and controls, produces conditioned outputs
  modport slave (
    input  iS, iMODE, iRETRIG, iCLR,
    output oS, oLEVEL, oEDGE, oOVR, oBUSY
  );

  // Controller side: drives strobes and controls, observes outputs
  modport master (
    output iS, iMODE, iRETRIG, iCLR,
    input  oS, oLEVEL, oEDGE, oOVR, oBUSY
  );
endinterface
`default_nettype wire

// File: rtl/multi_pulse_shaper.sv
`default_nettype none
// ============================================================================
// Module      : multi_pulse_shaper
// Description : N-channel strobe conditioner. Each channel runs
//               synchronizer -> debounce -> edge select -> retriggerable
//               pulse stretcher, with sticky overrun reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_pulse_shaper #(
  parameter int CH_NUM       = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_NUM = 4,
  parameter int EXPAND_NUM   = 8
) (
  input  wire                    CLK,
  input  wire                    RST_N,
  multi_pulse_shaper_if.slave    bus
);

  localparam int C_DB_W = $clog2(DEBOUNCE_NUM) + 1;
  localparam int C_EX_W = $clog2(EXPAND_NUM) + 1;
  localparam logic [C_DB_W-1:0] C_DB_MAX = C_DB_W'(DEBOUNCE_NUM - 1);
  localparam logic [C_EX_W-1:0] C_EX_MAX = C_EX_W'(EXPAND_NUM - 1);

  localparam logic [1:0] C_MODE_RISE = 2'b00;
  localparam logic [1:0] C_MODE_FALL = 2'b01;
  localparam logic [1:0] C_MODE_BOTH = 2'b10;

  logic [CH_NUM-1:0] w_sync;
  logic [CH_NUM-1:0] w_s;
  logic [CH_NUM-1:0] w_level;
  logic [CH_NUM-1:0] w_edge;
  logic [CH_NUM-1:0] w_ovr;

  // --------------------------------------------------------------------------
  // Synchronizer: zero stages only for strobes already in the CLK domain
  // --------------------------------------------------------------------------
  if (SYNC_STAGES == 0) begin : g_sync_bypass
    assign w_sync = bus.iS;
  end else begin : g_sync_chain
    logic [CH_NUM-1:0] r_sync [SYNC_STAGES];

    // Shift the raw strobes through the metastability chain
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
          r_sync[i] <= '0;
        end
      end else begin
        r_sync[0] <= bus.iS;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          r_sync[i] <= r_sync[i-1];
        end
      end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
  end

  // --------------------------------------------------------------------------
  // Per-channel debounce, edge select and stretcher
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    logic              r_lvl;
    logic [C_DB_W-1:0] r_db_cnt;
    logic              r_lvl_d;
    logic              r_s;
    logic              r_ovr;
    logic [C_EX_W-1:0] r_ex_cnt;
    logic              w_rise;
    logic              w_fall;
    logic              w_edge_ch;

    // Accept a new level only after it has persisted DEBOUNCE_NUM cycles
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_lvl    <= 1'b0;
        r_db_cnt <= '0;
      end else if (w_sync[gi] == r_lvl) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == C_DB_MAX) begin
        r_lvl    <= w_sync[gi];
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end

    // Keep last cycle's debounced level for edge detection
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_lvl_d <= 1'b0;
      end else begin
        r_lvl_d <= r_lvl;
      end
    end

    assign w_rise = r_lvl & ~r_lvl_d;
    assign w_fall = ~r_lvl & r_lvl_d;

    // Select which debounced transitions qualify as edges
    always_comb begin
      w_edge_ch = 1'b0;
      case (bus.iMODE)
        C_MODE_RISE: w_edge_ch = w_rise;
        C_MODE_FALL: w_edge_ch = w_fall;
        C_MODE_BOTH: w_edge_ch = w_rise | w_fall;
        default:     w_edge_ch = 1'b0;
      endcase
    end

    // Stretch qualifying edges; a refused retrigger only flags overrun and
    // the running countdown carries on so the pulse still ends on schedule
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_ex_cnt <= '0;
        r_s      <= 1'b0;
        r_ovr    <= 1'b0;
      end else if (bus.iCLR) begin
        r_ex_cnt <= '0;
        r_s      <= 1'b0;
        r_ovr    <= 1'b0;
      end else if (w_edge_ch && !r_s) begin
        r_ex_cnt <= C_EX_MAX;
        r_s      <= 1'b1;
      end else if (w_edge_ch && bus.iRETRIG) begin
        r_ex_cnt <= C_EX_MAX;
      end else begin
        if (w_edge_ch) begin
          r_ovr <= 1'b1;
        end
        if (r_ex_cnt != '0) begin
          r_ex_cnt <= r_ex_cnt - 1'b1;
        end else begin
          r_s <= 1'b0;
        end
      end
    end

    assign w_s[gi]     = r_s;
    assign w_level[gi] = r_lvl;
    assign w_edge[gi]  = w_edge_ch;
    assign w_ovr[gi]   = r_ovr;
  end

  assign bus.oS     = w_s;
  assign bus.oLEVEL = w_level;
  assign bus.oEDGE  = w_edge;
  assign bus.oOVR   = w_ovr;
  assign bus.oBUSY  = |w_s;

endmodule
`default_nettype wire
